// File: rtl/idu_pkg.sv
// idu_pkg: shared decode definitions for the RV32I decode stage (idu) and
// execute (exu). Holds opcode/funct3 constants, the 5-bit ALU op enum,
// operand-select encodings and the id_to_ex_bus layout.
// Build option: IDU_RV32M_EN enables decode of the M-extension ALU ops.
package idu_pkg;

  // Major opcodes
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

  // Branch funct3
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // M ops sit at 5'b10xxx so the low bits are simply funct3.
  typedef enum logic [4:0] {
    ALU_ADD    = 5'd0,  ALU_SUB   = 5'd1,  ALU_SLL  = 5'd2,  ALU_SLT  = 5'd3,
    ALU_SLTU   = 5'd4,  ALU_XOR   = 5'd5,  ALU_SRL  = 5'd6,  ALU_SRA  = 5'd7,
    ALU_OR     = 5'd8,  ALU_AND   = 5'd9,
    ALU_MUL    = 5'd16, ALU_MULH  = 5'd17, ALU_MULHSU = 5'd18, ALU_MULHU = 5'd19,
    ALU_DIV    = 5'd20, ALU_DIVU  = 5'd21, ALU_REM  = 5'd22, ALU_REMU = 5'd23
  } alu_op_e;

  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_e;

  // Operand selects. Operand 2 is either the imm lane or the constant 4;
  // formats without an immediate carry rs2 on the imm lane.
  localparam logic [1:0] SRC1_RS1  = 2'd0;
  localparam logic [1:0] SRC1_PC   = 2'd1;
  localparam logic [1:0] SRC1_ZERO = 2'd2;
  localparam logic       SRC2_IMM  = 1'b0;
  localparam logic       SRC2_C4   = 1'b1;

  // id_to_ex_bus layout, MSB first
  localparam int ID_EX_W        = 148;
  localparam int IDEX_PC_LSB    = 116;
  localparam int IDEX_IMM_LSB   = 84;
  localparam int IDEX_RS1_LSB   = 52;
  localparam int IDEX_RS2_LSB   = 20;
  localparam int IDEX_RD_LSB    = 15;
  localparam int IDEX_RDWEN_BIT = 14;
  localparam int IDEX_ALU_LSB   = 9;
  localparam int IDEX_SRC1_LSB  = 7;
  localparam int IDEX_SRC2_BIT  = 6;
  localparam int IDEX_MREN_BIT  = 5;
  localparam int IDEX_MWEN_BIT  = 4;
  localparam int IDEX_F3_LSB    = 1;
  localparam int IDEX_EBRK_BIT  = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [4:0]  rd;
    logic        rd_wen;
    alu_op_e     alu_op;
    logic [1:0]  src1_sel;
    logic        src2_sel;
    logic        mem_ren;
    logic        mem_wen;
    logic [2:0]  funct3;
    logic        is_ebreak;
  } id_ex_t;

  // ALU op for the funct7=0 OP / OP-IMM encodings
  function automatic alu_op_e base_alu(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/idu_imm_gen.sv
// idu_imm_gen: combinational immediate generator.
//   inst : held instruction
//   fmt  : immediate format implied by the opcode
//   imm  : sign-extended immediate (0 for formats without one)
module idu_imm_gen
  import idu_pkg::*;
(
  input  logic [31:0] inst,
  output imm_fmt_e    fmt,
  output logic [31:0] imm
);

  always_comb begin
    fmt = IMM_NONE;
    case (inst[6:0])
      OPC_LUI, OPC_AUIPC:              fmt = IMM_U;
      OPC_JAL:                         fmt = IMM_J;
      OPC_JALR, OPC_LOAD, OPC_OPIMM:   fmt = IMM_I;
      OPC_BRANCH:                      fmt = IMM_B;
      OPC_STORE:                       fmt = IMM_S;
      default:                         fmt = IMM_NONE;
    endcase
  end

  always_comb begin
    imm = '0;
    case (fmt)
      IMM_I:   imm = {{20{inst[31]}}, inst[31:20]};
      IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:   imm = {inst[31:12], 12'b0};
      IMM_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/idu.sv
// idu: RV32I decode stage. Holds one {pc, inst} from fetch, reads the
// register file, and forks the resolved next PC back to fetch and the
// decoded micro-op to execute; each branch handshakes independently.
// Ports: clk, rst (async active-low); if_to_id_* (fetch in), id_to_if_*
// (next PC out), id_to_ex_* (micro-op out), rf_raddr*/rf_rdata* (regfile),
// illegal_inst (held instruction undecodable).
// Build option: IDU_RV32M_EN decodes OP/funct7=0000001 as MUL..REMU;
// otherwise those encodings are illegal.
module idu
  import idu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             if_to_id_valid,
  output logic                             id_to_if_ready,
  input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] if_to_id_bus,
  output logic                             id_to_if_valid,
  input  logic                             if_to_id_ready,
  output logic [ADDR_WIDTH-1:0]            id_to_if_bus,
  output logic                             id_to_ex_valid,
  input  logic                             ex_to_id_ready,
  output logic [ID_EX_W-1:0]               id_to_ex_bus,
  output logic [4:0]                       rf_raddr1,
  output logic [4:0]                       rf_raddr2,
  input  logic [DATA_WIDTH-1:0]            rf_rdata1,
  input  logic [DATA_WIDTH-1:0]            rf_rdata2,
  output logic                             illegal_inst
);

  logic                  valid_q, sent_if, sent_ex;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] inst_q;
  logic                  if_done, ex_done, accept;

  // ---------------- handshake / holding register ----------------
  assign id_to_if_valid = valid_q & ~sent_if;
  assign id_to_ex_valid = valid_q & ~sent_ex;
  assign if_done        = sent_if | (id_to_if_valid & if_to_id_ready);
  assign ex_done        = sent_ex | (id_to_ex_valid & ex_to_id_ready);
  // Ready while the last branch completes, so the next inst can load same edge.
  assign id_to_if_ready = ~valid_q | (if_done & ex_done);
  assign accept         = if_to_id_valid & id_to_if_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      sent_if <= 1'b0;
      sent_ex <= 1'b0;
      pc_q    <= '0;
      inst_q  <= '0;
    end else if (accept) begin
      pc_q    <= if_to_id_bus[ADDR_WIDTH+DATA_WIDTH-1 -: ADDR_WIDTH];
      inst_q  <= if_to_id_bus[DATA_WIDTH-1:0];
      valid_q <= 1'b1;
      sent_if <= 1'b0;
      sent_ex <= 1'b0;
    end else if (valid_q) begin
      if (if_done && ex_done) begin
        valid_q <= 1'b0;
        sent_if <= 1'b0;
        sent_ex <= 1'b0;
      end else begin
        sent_if <= if_done;
        sent_ex <= ex_done;
      end
    end
  end

  // ---------------- decode ----------------
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] rd;
  assign opcode    = inst_q[6:0];
  assign rd        = inst_q[11:7];
  assign funct3    = inst_q[14:12];
  assign funct7    = inst_q[31:25];
  assign rf_raddr1 = inst_q[19:15];
  assign rf_raddr2 = inst_q[24:20];

  imm_fmt_e    fmt;
  logic [31:0] imm;

  idu_imm_gen u_imm_gen (
    .inst (inst_q),
    .fmt  (fmt),
    .imm  (imm)
  );

  logic    illegal, rd_wen, mem_ren, mem_wen, is_ebreak;
  logic    is_br, is_jal, is_jalr, br_taken;
  alu_op_e alu_op;
  logic [1:0] src1_sel;
  logic       src2_sel;

  always_comb begin
    illegal   = 1'b0;
    rd_wen    = 1'b0;
    mem_ren   = 1'b0;
    mem_wen   = 1'b0;
    is_ebreak = 1'b0;
    is_br     = 1'b0;
    is_jal    = 1'b0;
    is_jalr   = 1'b0;
    alu_op    = ALU_ADD;
    src1_sel  = SRC1_RS1;
    src2_sel  = SRC2_IMM;
    case (opcode)
      OPC_LUI:   begin rd_wen = 1'b1; src1_sel = SRC1_ZERO; end
      OPC_AUIPC: begin rd_wen = 1'b1; src1_sel = SRC1_PC; end
      OPC_JAL: begin
        rd_wen = 1'b1; src1_sel = SRC1_PC; src2_sel = SRC2_C4; is_jal = 1'b1;
      end
      OPC_JALR: begin
        rd_wen = 1'b1; src1_sel = SRC1_PC; src2_sel = SRC2_C4; is_jalr = 1'b1;
        illegal = (funct3 != 3'b000);
      end
      OPC_BRANCH: begin
        is_br   = 1'b1;
        illegal = (funct3[2:1] == 2'b01);
      end
      OPC_LOAD: begin
        rd_wen = 1'b1; mem_ren = 1'b1;
        illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
      end
      OPC_STORE: begin
        mem_wen = 1'b1;
        illegal = (funct3 > 3'b010);
      end
      OPC_OPIMM: begin
        rd_wen = 1'b1;
        alu_op = base_alu(funct3);
        if (funct3 == 3'b001) illegal = (funct7 != 7'h00);
        else if (funct3 == 3'b101) begin
          if (funct7 == 7'h20) alu_op = ALU_SRA;
          else                 illegal = (funct7 != 7'h00);
        end
      end
      OPC_OP: begin
        rd_wen = 1'b1;
        case (funct7)
          7'h00: alu_op = base_alu(funct3);
          7'h20: begin
            if (funct3 == 3'b000)      alu_op = ALU_SUB;
            else if (funct3 == 3'b101) alu_op = ALU_SRA;
            else                       illegal = 1'b1;
          end
          7'h01: begin
`ifdef IDU_RV32M_EN
            alu_op = alu_op_e'({2'b10, funct3});
`else
            illegal = 1'b1;
`endif
          end
          default: illegal = 1'b1;
        endcase
      end
      OPC_SYSTEM: begin
        is_ebreak = (inst_q == INST_EBREAK);
        illegal   = (inst_q != INST_ECALL) && (inst_q != INST_EBREAK);
      end
      default: illegal = 1'b1;
    endcase
    // Illegal instructions must have no side effects and fall through to pc+4.
    if (illegal) begin
      rd_wen = 1'b0; mem_ren = 1'b0; mem_wen = 1'b0; is_ebreak = 1'b0;
      is_br  = 1'b0; is_jal  = 1'b0; is_jalr = 1'b0;
    end
    if (rd == 5'd0) rd_wen = 1'b0;
  end

  // ---------------- next PC ----------------
  always_comb begin
    case (funct3)
      F3_BEQ:  br_taken = (rf_rdata1 == rf_rdata2);
      F3_BNE:  br_taken = (rf_rdata1 != rf_rdata2);
      F3_BLT:  br_taken = ($signed(rf_rdata1) <  $signed(rf_rdata2));
      F3_BGE:  br_taken = ($signed(rf_rdata1) >= $signed(rf_rdata2));
      F3_BLTU: br_taken = (rf_rdata1 <  rf_rdata2);
      F3_BGEU: br_taken = (rf_rdata1 >= rf_rdata2);
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    id_to_if_bus = pc_q + 32'd4;
    if ((is_br && br_taken) || is_jal) id_to_if_bus = pc_q + imm;
    else if (is_jalr)                  id_to_if_bus = (rf_rdata1 + imm) & ~32'd1;
  end

  // ---------------- micro-op bus ----------------
  id_ex_t op;
  always_comb begin
    op.pc        = pc_q;
    // No-immediate formats (R-type, SYSTEM) forward rs2 on the imm lane so
    // execute's operand-2 mux is only imm vs. const 4.
    op.imm       = (fmt == IMM_NONE) ? rf_rdata2 : imm;
    op.rs1_data  = rf_rdata1;
    op.rs2_data  = rf_rdata2;
    op.rd        = rd;
    op.rd_wen    = rd_wen;
    op.alu_op    = alu_op;
    op.src1_sel  = src1_sel;
    op.src2_sel  = src2_sel;
    op.mem_ren   = mem_ren;
    op.mem_wen   = mem_wen;
    op.funct3    = funct3;
    op.is_ebreak = is_ebreak;
  end

  assign id_to_ex_bus = op;
  assign illegal_inst = valid_q & illegal;

endmodule
